// File: rtl/cgra_config_loader_if.sv
// Configuration word stream between a word source and cgra_config_loader.
interface cgra_config_loader_if #(
  parameter int WORD = 32
);
  logic [WORD-1:0] word_in;
  logic            word_valid;
  logic            word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/cgra_config_loader.sv
// Serial loader for a CGRA configuration chain: clears the chain, then shifts
// exactly CHAIN_LEN bits (LSB first) from a valid/ready word stream.
module cgra_config_loader #(
  parameter int WORD      = 32,
  parameter int CHAIN_LEN = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  cgra_config_loader_if.slave  wif,
  output logic                 config_clk,
  output logic                 config_reset,
  output logic                 config_data,
  output logic                 busy,
  output logic                 done
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(WORD + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] LAST_POS = PW'(WORD - 1);

  typedef enum logic [2:0] {IDLE, CLR0, CLR1, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t          state_q, state_d;
  logic [WORD-1:0] sreg;
  logic [WORD-1:0] sreg_shr;
  logic [BW-1:0]   bit_cnt;
  logic [PW-1:0]   pos_cnt;

  assign sreg_shr = sreg >> 1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = CLR0;
      CLR0:     state_d = CLR1;
      CLR1:     state_d = LOAD;
      LOAD:     if (wif.word_valid) state_d = SHIFT_LO;
      SHIFT_LO: state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (bit_cnt == LAST_BIT)      state_d = DONE;
        else if (pos_cnt == LAST_POS) state_d = LOAD;
        else                          state_d = SHIFT_LO;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      sreg           <= '0;
      bit_cnt        <= '0;
      pos_cnt        <= '0;
      config_clk     <= 1'b0;
      config_reset   <= 1'b0;
      config_data    <= 1'b0;
      wif.word_ready <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      config_clk     <= (state_d == SHIFT_HI);
      config_reset   <= (state_d == CLR0) || (state_d == CLR1);
      wif.word_ready <= (state_d == LOAD);
      busy           <= (state_d != IDLE);
      done           <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          config_data <= 1'b0;
          if (start) begin
            bit_cnt <= '0;
            pos_cnt <= '0;
          end
        end
        LOAD: begin
          if (wif.word_valid) begin
            sreg        <= wif.word_in;
            config_data <= wif.word_in[0];
            pos_cnt     <= '0;
          end
        end
        SHIFT_HI: begin
          // Data only moves on the falling config_clk edge, never the rising one.
          sreg    <= sreg_shr;
          bit_cnt <= bit_cnt + 1'b1;
          pos_cnt <= pos_cnt + 1'b1;
          if (state_d == SHIFT_LO) config_data <= sreg_shr[0];
        end
        DONE:    config_data <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench: two loaders (CHAIN_LEN 12 and 16, WORD 8) share one stimulus.
module tb_cgra_config_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] word_in;
  logic       word_valid;
  logic       mon_clr;

  logic [1:0] cclk, creset, cdata, cbusy, cdone, wready;

  always #5 clk = ~clk;

  cgra_config_loader_if #(.WORD(8)) wa ();
  cgra_config_loader_if #(.WORD(8)) wb ();
  assign wa.word_in = word_in;  assign wa.word_valid = word_valid;
  assign wb.word_in = word_in;  assign wb.word_valid = word_valid;
  assign wready[0] = wa.word_ready;
  assign wready[1] = wb.word_ready;

  cgra_config_loader #(.WORD(8), .CHAIN_LEN(12)) u_a (
    .clk(clk), .reset(reset), .start(start), .wif(wa.slave),
    .config_clk(cclk[0]), .config_reset(creset[0]), .config_data(cdata[0]),
    .busy(cbusy[0]), .done(cdone[0]));

  cgra_config_loader #(.WORD(8), .CHAIN_LEN(16)) u_b (
    .clk(clk), .reset(reset), .start(start), .wif(wb.slave),
    .config_clk(cclk[1]), .config_reset(creset[1]), .config_data(cdata[1]),
    .busy(cbusy[1]), .done(cdone[1]));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor at negedge: capture bits at config_clk rises, count events, spot glitches.
  int          cyc = 0;
  int          cnt[2], ndone[2], nrst[2], nhs[2], busy_rise[2], done_at[2], glitch[2];
  logic [31:0] cap[2];
  logic [1:0]  pclk = '0, pdata = '0, pbusy = '0;

  initial for (int d = 0; d < 2; d++) glitch[d] = 0;

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (cclk[d] && !pclk[d] && (cdata[d] != pdata[d])) glitch[d]++;
      if (mon_clr) begin
        cnt[d] = 0; cap[d] = '0; ndone[d] = 0; nrst[d] = 0; nhs[d] = 0;
        busy_rise[d] = -1; done_at[d] = -1;
      end else begin
        if (cclk[d] && !pclk[d]) begin
          if (cnt[d] < 32) cap[d][cnt[d]] = cdata[d];
          cnt[d]++;
        end
        if (cdone[d]) begin
          ndone[d]++;
          if (done_at[d] < 0) done_at[d] = cyc;
        end
        if (cbusy[d] && !pbusy[d] && busy_rise[d] < 0) busy_rise[d] = cyc;
        if (creset[d]) nrst[d]++;
        if (word_valid && wready[d]) nhs[d]++;
      end
    end
    pclk = cclk; pdata = cdata; pbusy = cbusy;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!wready[0] && n < 200) begin tick(); n++; end
    if (n >= 200) chk({name, " ready timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [7:0]  w0, w1;
    int          stall;
    bit          poke;
    logic [15:0] exp12, exp16;
    int          lat12, lat16;
  } vec_t;

  vec_t vt[5];

  // Latency is counted from the cycle busy first goes high to the cycle done is high.
  task automatic run_scn(input int i);
    int n;
    string s;
    s = $sformatf("s%0d", i);
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    start = 1'b1; word_valid = 1'b1; word_in = vt[i].w0;
    tick(); start = 1'b0;
    wait_ready(s);
    tick();
    word_in = vt[i].w1;
    if (vt[i].poke) begin start = 1'b1; tick(); start = 1'b0; end
    if (vt[i].stall > 0) begin
      word_valid = 1'b0;
      wait_ready(s);
      for (int k = 0; k < vt[i].stall; k++) begin
        chk($sformatf("%s stall clk", s), int'(cclk), 0);
        chk($sformatf("%s stall ready", s), int'(wready), 3);
        tick();
      end
      word_valid = 1'b1;
    end
    wait_ready(s);
    tick();
    word_in = 8'hFF;
    n = 0;
    while ((done_at[0] < 0 || done_at[1] < 0) && n < 300) begin tick(); n++; end
    if (n >= 300) chk({s, " done timeout"}, 0, 1);
    repeat (4) tick();
    word_valid = 1'b0;
    chk({s, " A bits"},  int'(cap[0]), int'(vt[i].exp12[11:0]));
    chk({s, " A count"}, cnt[0], 12);
    chk({s, " A lat"},   done_at[0] - busy_rise[0], vt[i].lat12);
    chk({s, " A done"},  ndone[0], 1);
    chk({s, " A clr"},   nrst[0], 2);
    chk({s, " A hs"},    nhs[0], 2);
    chk({s, " B bits"},  int'(cap[1]), int'(vt[i].exp16));
    chk({s, " B count"}, cnt[1], 16);
    chk({s, " B lat"},   done_at[1] - busy_rise[1], vt[i].lat16);
    chk({s, " B done"},  ndone[1], 1);
    chk({s, " B clr"},   nrst[1], 2);
    chk({s, " B hs"},    nhs[1], 2);
  endtask

  initial begin
    int n;
    vt[0] = '{w0: 8'hA5, w1: 8'h3C, stall: 0, poke: 1'b0, exp12: 16'h0CA5, exp16: 16'h3CA5, lat12: 28, lat16: 36};
    vt[1] = '{w0: 8'hA5, w1: 8'h3C, stall: 5, poke: 1'b0, exp12: 16'h0CA5, exp16: 16'h3CA5, lat12: 33, lat16: 41};
    vt[2] = '{w0: 8'hFF, w1: 8'h00, stall: 0, poke: 1'b0, exp12: 16'h00FF, exp16: 16'h00FF, lat12: 28, lat16: 36};
    vt[3] = '{w0: 8'h5A, w1: 8'hC3, stall: 2, poke: 1'b0, exp12: 16'h035A, exp16: 16'hC35A, lat12: 30, lat16: 38};
    vt[4] = '{w0: 8'hA5, w1: 8'h3C, stall: 0, poke: 1'b1, exp12: 16'h0CA5, exp16: 16'h3CA5, lat12: 28, lat16: 36};

    reset = 1'b0; start = 1'b0; word_in = '0; word_valid = 1'b0; mon_clr = 1'b1;
    repeat (2) tick();
    chk("reset outs A", int'({cbusy[0], cdone[0], cclk[0], creset[0], cdata[0], wready[0]}), 0);
    chk("reset outs B", int'({cbusy[1], cdone[1], cclk[1], creset[1], cdata[1], wready[1]}), 0);
    reset = 1'b1;
    tick();

    // Valid word offered while idle must not be accepted.
    word_valid = 1'b1; word_in = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle ready %0d", k), int'(wready), 0);
      chk($sformatf("idle busy %0d", k), int'(cbusy), 0);
      tick();
    end
    word_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_scn(i);

    // Asynchronous reset between clock edges during the 5th bit.
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    start = 1'b1; word_valid = 1'b1; word_in = 8'hA5;
    tick(); start = 1'b0;
    n = 0;
    while (cnt[0] < 4 && n < 100) begin tick(); n++; end
    if (n >= 100) chk("rst bit wait timeout", 0, 1);
    tick();
    chk("pre-rst busy", int'(cbusy), 3);
    #2 reset = 1'b0;
    #1;
    chk("async rst A", int'({cbusy[0], cdone[0], cclk[0], creset[0], cdata[0], wready[0]}), 0);
    chk("async rst B", int'({cbusy[1], cdone[1], cclk[1], creset[1], cdata[1], wready[1]}), 0);
    word_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_scn(0);

    chk("glitch A", glitch[0], 0);
    chk("glitch B", glitch[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cgra_config_loader.md
# cgra_config_loader

Serial configuration loader that sits directly upstream of a CGRA block's configuration chain. It accepts configuration words over a valid/ready stream and drives the chain's `config_clk`, `config_reset` and serial `config_in` input. It shifts exactly `CHAIN_LEN` bits, then reports completion. One loader serves one chain, such as a PE tile's concatenated `config_cell` and crossbar bits.

## Interface
- `WORD`, default 32: width of an incoming configuration word.
- `CHAIN_LEN`, default 64: total number of bits in the downstream chain; must be ≥1.
- `clk`  in  1  system clock; all state is registered on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `word_in`  in  WORD  configuration word; bit 0 is shifted first.
- `word_valid`  in  1  `word_in` holds a valid word.
- `word_ready`  out  1  loader accepts `word_in` this cycle.
- `config_clk`  out  1  registered shift clock to the chain.
- `config_reset`  out  1  registered, active-high clear to the chain's config cells.
- `config_data`  out  1  serial bit to the chain's `config_in`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last bit has been shifted.

## Operation
- **Derived constants:**
  - `NWORDS = ceil(CHAIN_LEN/WORD)`.
  - The bit counter counts 0..CHAIN_LEN and is `$clog2(CHAIN_LEN+1)` bits wide.
  - The word counter counts 0..NWORDS.
- **States:** IDLE, CLR0, CLR1, LOAD, SHIFT_LO, SHIFT_HI, DONE.
- **IDLE:**
  - All outputs are 0.
  - `start`=1 → CLR0, and the bit counter is cleared.
  - `start` in any other state is ignored.
- **CLR0, CLR1:**
  - `config_reset`=1 and `config_clk`=0.
  - CLR0 → CLR1 → LOAD.
- **LOAD:**
  - `word_ready`=1 and `config_clk`=0.
  - On `word_valid`=1, `word_in` is captured into the shift register and the state moves to SHIFT_LO.
  - On `word_valid`=0, the state holds indefinitely with no `config_clk` edges.
- **SHIFT_LO:**
  - `config_clk`=0 and `config_data` = shift register bit 0; `config_data` is registered and updated on entry.
  - → SHIFT_HI.
- **SHIFT_HI:**
  - `config_clk`=1; this is the chain's sampling edge.
  - The shift register shifts right by 1 and the bit counter increments.
  - If the bit counter reaches CHAIN_LEN → DONE.
  - Else if WORD bits of the current word have been sent → LOAD.
  - Else → SHIFT_LO.
- **Last word:** only its first `CHAIN_LEN - (NWORDS-1)*WORD` bits are shifted; its upper bits are discarded.
- **DONE:**
  - `done`=1 and `config_clk`=0.
  - → IDLE.
- **Glitch rules:**
  - `config_data` changes only on a clk edge where `config_clk` is 0 or falling.
  - `config_data` is never changed on the edge that raises `config_clk`.
- **Reset:**
  - `reset`=0 forces IDLE and clears all registers and outputs to 0 immediately, independent of `clk`.
  - A partially loaded chain is not restored. Software must re-issue `start`, which clears the chain through CLR0/CLR1.

## Timing
- Let `start` be sampled at edge E0. Then:
  - `config_reset` is high during cycles E1–E2.
  - `word_ready` first asserts at E3.
- Each bit costs 2 clk cycles; `config_clk` runs at clk/2 with a 50% duty cycle while shifting.
- Each word costs 1 LOAD cycle plus 2 cycles per shifted bit.
- With `word_valid` held high, total latency from `start` to `done` is 2 + NWORDS + 2·CHAIN_LEN cycles; `done` is high in the last of these.
- `busy` rises one cycle after `start` and falls the cycle after `done`.
- **Stalls:** a `word_valid` stall only stretches LOAD. Once a word is accepted there are no bubbles in SHIFT.
- **Handshake:** a word transfers on any edge with `word_valid`=1 and `word_ready`=1. `word_ready` is never high outside LOAD.

## Test plan
All scenarios use WORD=8 and CHAIN_LEN=12 unless noted.

- **Basic load:** `start`, then words 0xA5 and 0x3C, `word_valid` always high.
  - Sampled `config_data` sequence at `config_clk` rising edges: 1,0,1,0,0,1,0,1,0,0,1,1.
  - Exactly 12 rising edges; `done` at cycle 2+2+24=28 after `start`.
  - Bits 7:4 of 0x3C are never driven.
- **Stall:** hold `word_valid` low for 5 cycles before the second word.
  - `config_clk` stays 0 and `word_ready` stays 1 throughout the stall.
  - `done` is delayed by exactly 5 cycles; the bit sequence is unchanged.
- **Ignored inputs:**
  - `start` pulsed while `busy` → no restart.
  - `word_valid`=1 in IDLE → `word_ready`=0 and no capture.
- **Reset mid-shift:** drive `reset` low between clk edges during the 5th bit.
  - All outputs go to 0 asynchronously; state is IDLE.
  - A subsequent `start` re-pulses `config_reset` for 2 cycles and reloads all 12 bits.
- **Exact multiple:** CHAIN_LEN=16 with 0xFF, 0x00.
  - 8 ones then 8 zeros; `done` at 2+2+32=36 cycles; no third `word_ready`.
- **Glitch check:** assertion that `config_data` never toggles on an edge where `config_clk` rises 0→1, across all scenarios.
